// File: rtl/riscv_run_controller_if.sv
// Program-load stream from the host plus the instruction-memory write port it drives.
// The controller takes the slave side; the host/loader takes the master side.
interface riscv_run_controller_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              load_valid;
   logic              load_ready;
   logic [31:0]       load_data;
   logic              load_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/riscv_run_controller.sv
// Boot/run sequencer: loads a program into imem with the core held in reset, then runs
// the core until its PC leaves the program or the cycle watchdog expires.
module riscv_run_controller #(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   riscv_run_controller_if.slave    ldr,
   output logic                     core_rst,
   output logic                     core_run,
   input  logic [31:0]              pc_in,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [ADDR_W:0]          prog_len,
   output logic [CNT_W-1:0]         cycles_run
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic [CNT_W-1:0]  cycles_run_q, cycles_run_d;
   logic              timeout_q, timeout_d;
   logic              core_rst_q, core_rst_d;
   logic              core_run_q, core_run_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load_ready_q, load_ready_d;

   logic              xfer;
   logic              pc_end;
   logic [CNT_W-1:0]  cycles_inc;
   logic [29:0]       pc_word;
   logic              unused_pc_lsb;

   assign pc_word       = pc_in[31:2];
   assign unused_pc_lsb = ^pc_in[1:0];
   assign xfer          = ldr.load_valid & load_ready_q;
   assign pc_end        = (pc_word >= 30'(prog_len_q));
   assign cycles_inc    = cycles_run_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      prog_len_d   = prog_len_q;
      cycles_run_d = cycles_run_q;
      timeout_d    = timeout_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LOAD;
               prog_len_d = '0;
               timeout_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               prog_len_d = prog_len_q + 1'b1;
               if (ldr.load_last || (prog_len_q[ADDR_W-1:0] == '1)) begin
                  state_d      = ST_RUN;
                  cycles_run_d = '0;
               end
            end
         end
         ST_RUN: begin
            // The exit cycle (PC already past the program) is not counted as a run cycle.
            if (pc_end) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
            end else begin
               cycles_run_d = cycles_inc;
               if (cycles_inc == CNT_W'(MAX_CYCLES)) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered with it.
      core_rst_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
      core_run_d   = (state_d == ST_RUN);
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d       = (state_d == ST_DONE);
      load_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prog_len_q   <= '0;
         cycles_run_q <= '0;
         timeout_q    <= 1'b0;
         core_rst_q   <= 1'b1;
         core_run_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_len_q   <= prog_len_d;
         cycles_run_q <= cycles_run_d;
         timeout_q    <= timeout_d;
         core_rst_q   <= core_rst_d;
         core_run_q   <= core_run_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign ldr.load_ready = load_ready_q;
   assign ldr.imem_we    = xfer;
   assign ldr.imem_waddr = prog_len_q[ADDR_W-1:0];
   assign ldr.imem_wdata = ldr.load_data;

   assign core_rst   = core_rst_q;
   assign core_run   = core_run_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign prog_len   = prog_len_q;
   assign cycles_run = cycles_run_q;

endmodule
